// File: rtl/reg_write_strober.sv
// reg_write_strober
//   Writer end of an asynchronous-strobe register interface. Single-bit writes
//   are queued in a small FIFO. Each write is replayed on a shared data line
//   (d_out) and a one-hot write strobe (c_out[sel]). The sequence for every
//   write is: data setup, then strobe high, then strobe low with data held.
//   The receiving registers sample on the falling edge of clock and treat a
//   0->1 transition of their strobe bit as a write.
//
// Parameters
//   NREG  : number of target registers (width of c_out), >= 2
//   DEPTH : write FIFO entries, power of two, >= 2
//   SETUP : cycles d_out is stable before the strobe rises, >= 1
//   HIGH  : cycles the strobe is held high, >= 1
//   HOLD  : cycles the strobe is low with d_out held after it falls, >= 1
//
// Ports
//   clock    : system clock, all logic on the rising edge
//   resetn   : synchronous active-low reset
//   wr_valid : write request
//   wr_ready : FIFO can accept (not full)
//   wr_sel   : target register index
//   wr_d     : value to write
//   c_out    : one-hot write strobes (registered)
//   d_out    : shared data line (registered)
//   busy     : sequencer active or writes pending (registered)
//   sel_err  : one-cycle pulse when a popped write targets index >= NREG

module reg_write_strober #(
    parameter int unsigned NREG  = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SETUP = 1,
    parameter int unsigned HIGH  = 2,
    parameter int unsigned HOLD  = 1,
    localparam int unsigned SW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [SW-1:0]   wr_sel,
    input  logic            wr_d,
    output logic [NREG-1:0] c_out,
    output logic            d_out,
    output logic            busy,
    output logic            sel_err
);

    // ------------------------------------------------------------------
    // Local sizing
    // ------------------------------------------------------------------
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam int unsigned MaxLen01 = (SETUP > HIGH) ? SETUP : HIGH;
    localparam int unsigned MaxLen   = (MaxLen01 > HOLD) ? MaxLen01 : HOLD;
    localparam int unsigned CW       = (MaxLen < 2) ? 1 : $clog2(MaxLen);

    localparam logic [CW-1:0] SetupLast = CW'(SETUP - 1);
    localparam logic [CW-1:0] HighLast  = CW'(HIGH - 1);
    localparam logic [CW-1:0] HoldLast  = CW'(HOLD - 1);

    // Sequencer states
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StStrobe = 2'd2;
    localparam logic [1:0] StHolds  = 2'd3;

    // ------------------------------------------------------------------
    // Write FIFO
    // ------------------------------------------------------------------
    logic [SW-1:0] mem_sel_q [DEPTH];
    logic          mem_d_q   [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [SW-1:0] head_sel;
    logic          head_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign full  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

    assign wr_ready = ~full;
    assign push     = wr_valid & ~full;

    assign head_sel = mem_sel_q[rptr_q[AW-1:0]];
    assign head_d   = mem_d_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset; only entries between the pointers are read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_sel_q[wptr_q[AW-1:0]] <= wr_sel;
            mem_d_q[wptr_q[AW-1:0]]   <= wr_d;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] cur_sel_q, cur_sel_d;
    logic          cur_d_q, cur_d_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == SetupLast) begin
                    cnt_d   = '0;
                    state_d = StStrobe;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StStrobe: begin
                if (cnt_q == HighLast) begin
                    cnt_d   = '0;
                    state_d = StHolds;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StHolds: begin
                if (cnt_q == HoldLast) begin
                    cnt_d = '0;
                    // Chain straight into the next write to keep throughput.
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StSetup;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        cur_sel_d = cur_sel_q;
        cur_d_d   = cur_d_q;
        if (pop) begin
            cur_sel_d = head_sel;
            cur_d_d   = head_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cur_sel_q <= '0;
            cur_d_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
            cur_d_q   <= cur_d_d;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs, derived from the current sequencer state so the
    // line levels trail the state by exactly one cycle.
    // ------------------------------------------------------------------
    logic [NREG-1:0] strobe_vec;
    logic            sel_invalid;
    logic [NREG-1:0] c_out_q, c_out_d;
    logic            d_out_q, d_out_d;
    logic            busy_q, busy_d;
    logic            sel_err_q, sel_err_d;

    // Index outside 0..NREG-1 matches no bit and therefore strobes nothing.
    always_comb begin
        strobe_vec = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (cur_sel_q == SW'(i)) begin
                strobe_vec[i] = 1'b1;
            end
        end
    end

    assign sel_invalid = ~|strobe_vec;

    always_comb begin
        c_out_d   = '0;
        d_out_d   = d_out_q;
        sel_err_d = 1'b0;
        busy_d    = (state_q != StIdle) || !empty;

        case (state_q)
            StIdle: begin
                d_out_d = d_out_q;
            end
            StSetup: begin
                d_out_d = cur_d_q;
            end
            StStrobe: begin
                d_out_d   = cur_d_q;
                c_out_d   = strobe_vec;
                sel_err_d = sel_invalid && (cnt_q == '0);
            end
            StHolds: begin
                d_out_d = cur_d_q;
            end
            default: begin
                d_out_d = d_out_q;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            c_out_q   <= '0;
            d_out_q   <= 1'b0;
            busy_q    <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            c_out_q   <= c_out_d;
            d_out_q   <= d_out_d;
            busy_q    <= busy_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign c_out   = c_out_q;
    assign d_out   = d_out_q;
    assign busy    = busy_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_reg_write_strober.sv
// Testbench for reg_write_strober. A receiver model watches c_out on the
// falling edge of clock and records every 0->1 strobe as a write, checking
// it against the queue of accepted writes and the sequencing timing rules.
// A second instance with NREG=5 exposes out-of-range selects (sel=7).

module tb_reg_write_strober;

    localparam int NREG  = 8;
    localparam int DEPTH = 4;
    localparam int SETUP = 1;
    localparam int HIGH  = 2;
    localparam int HOLD  = 1;
    localparam int PERIOD = SETUP + HIGH + HOLD;

    typedef struct {
        int   sel;
        logic d;
    } wr_t;

    logic       clock = 1'b0;
    logic       resetn;
    logic       wr_valid;
    logic [2:0] wr_sel;
    logic       wr_d;

    logic       wr_ready;
    logic [7:0] c_out;
    logic       d_out;
    logic       busy;
    logic       sel_err;

    logic       wr_ready2;
    logic [4:0] c_out2;
    logic       d_out2;
    logic       busy2;
    logic       sel_err2;

    reg_write_strober u_dut (
        .clock   (clock),
        .resetn  (resetn),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_sel  (wr_sel),
        .wr_d    (wr_d),
        .c_out   (c_out),
        .d_out   (d_out),
        .busy    (busy),
        .sel_err (sel_err)
    );

    reg_write_strober #(.NREG(5)) u_dut_err (
        .clock   (clock),
        .resetn  (resetn),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready2),
        .wr_sel  (wr_sel),
        .wr_d    (wr_d),
        .c_out   (c_out2),
        .d_out   (d_out2),
        .busy    (busy2),
        .sel_err (sel_err2)
    );

    always #5 clock = ~clock;

    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    // Receiver / scoreboard state
    wr_t  exp_q[$];
    logic [7:0] prev_c = '0;
    int   high_len = 0;
    int   gap = 0;
    int   last_gap = 0;
    bit   gap_valid = 0;
    int   hold_left = 0;
    logic latch_d = 1'b0;
    logic rx [8];
    logic rx_exp [8];
    int   strobe_cnt = 0;

    int   err2_pulses = 0;
    int   err2_pulse_cyc = 0;
    int   err2_high_cnt = 0;
    logic [4:0] err2_last_c = '0;
    int   main_err_cnt = 0;

    int   bw_sel [8];
    logic bw_d [8];
    int   first_push_cyc = 0;

    task automatic monitor_sample();
        int  s;
        wr_t w;
        if (!resetn) begin
            exp_q.delete();
            prev_c    = '0;
            high_len  = 0;
            gap       = 0;
            gap_valid = 0;
            hold_left = 0;
            return;
        end
        s = 0;
        for (int i = 0; i < NREG; i++) if (c_out[i]) s = i;
        vectors++;
        if ((c_out & (c_out - 8'd1)) != 8'd0) begin
            errors++;
            $display("FAIL onehot: c_out=%b, required at most one bit set", c_out);
        end
        if (prev_c == 8'd0 && c_out != 8'd0) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: c_out=%b with no write pending", c_out);
            end else begin
                w = exp_q.pop_front();
                if (s != w.sel || d_out !== w.d) begin
                    errors++;
                    $display("FAIL strobe_order: sel=%0d d=%b, required sel=%0d d=%b",
                             s, d_out, w.sel, w.d);
                end
            end
            if (gap_valid) begin
                vectors++;
                if (gap < HOLD + SETUP) begin
                    errors++;
                    $display("FAIL strobe_gap: low for %0d cycles, required >= %0d",
                             gap, HOLD + SETUP);
                end
            end
            last_gap = gap;
            rx[s]    = d_out;
            latch_d  = d_out;
            high_len = 1;
            strobe_cnt++;
        end else if (prev_c != 8'd0 && c_out != 8'd0) begin
            vectors++;
            if (c_out !== prev_c || d_out !== latch_d) begin
                errors++;
                $display("FAIL strobe_stable: c_out=%b d=%b, required c_out=%b d=%b",
                         c_out, d_out, prev_c, latch_d);
            end
            high_len++;
        end else if (prev_c != 8'd0 && c_out == 8'd0) begin
            vectors++;
            if (high_len != HIGH) begin
                errors++;
                $display("FAIL strobe_width: high %0d cycles, required %0d", high_len, HIGH);
            end
            vectors++;
            if (d_out !== latch_d) begin
                errors++;
                $display("FAIL data_hold: d_out=%b, required %b", d_out, latch_d);
            end
            gap       = 1;
            gap_valid = 1;
            hold_left = HOLD - 1;
        end else begin
            gap++;
            if (hold_left > 0) begin
                vectors++;
                if (d_out !== latch_d) begin
                    errors++;
                    $display("FAIL data_hold: d_out=%b, required %b", d_out, latch_d);
                end
                hold_left--;
            end
        end
        prev_c = c_out;

        if (c_out2 != 5'd0) begin
            err2_high_cnt++;
            err2_last_c = c_out2;
        end
        if (sel_err2) begin
            err2_pulses++;
            err2_pulse_cyc = cyc;
        end
        if (sel_err) main_err_cnt++;
    endtask

    // One clock cycle: sample at the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clock);
        monitor_sample();
        @(posedge clock);
        cyc++;
        #1;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (busy === 1'b1 && w < 400) begin
            tick();
            w++;
        end
        tick();
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: busy=%b, required 0", busy);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL writes_lost: %0d writes never strobed, required 0", exp_q.size());
        end
    endtask

    // Offers writes bw_* according to skip mask, with an occupancy model that
    // assumes the block starts idle and stays busy for the whole burst.
    task automatic drive_burst(input int n, input logic [31:0] skip);
        int   cnt, next_pop, idx, k;
        bit   offer, mready, pop_m, push_m;
        wr_t  w;
        cnt = 0; next_pop = -1; idx = 0; k = 0;
        while (idx < n && k < 40) begin
            offer  = (k < 32) ? !skip[k] : 1'b1;
            mready = (cnt < DEPTH);
            vectors++;
            if (wr_ready !== mready) begin
                errors++;
                $display("FAIL wr_ready: cycle %0d of burst got %b, required %b",
                         k, wr_ready, mready);
            end
            wr_valid = offer;
            wr_sel   = 3'(bw_sel[idx]);
            wr_d     = bw_d[idx];
            pop_m    = (k == next_pop) && (cnt > 0);
            push_m   = offer && mready;
            if (push_m) begin
                w.sel = bw_sel[idx];
                w.d   = bw_d[idx];
                exp_q.push_back(w);
            end
            tick();
            if (push_m && idx == 0) first_push_cyc = cyc;
            if (pop_m) next_pop = next_pop + PERIOD;
            if (push_m && next_pop < 0) next_pop = k + 1;
            cnt = cnt + int'(push_m) - int'(pop_m);
            if (push_m) idx++;
            k++;
        end
        wr_valid = 1'b0;
        vectors++;
        if (idx != n) begin
            errors++;
            $display("FAIL burst_timeout: %0d of %0d writes accepted", idx, n);
        end
    endtask

    task automatic push_one(input int sel, input logic d);
        bit  acc;
        wr_t w;
        acc      = 0;
        wr_valid = 1'b1;
        wr_sel   = 3'(sel);
        wr_d     = d;
        for (int i = 0; i < 60 && !acc; i++) begin
            if (wr_ready === 1'b1) begin
                acc   = 1;
                w.sel = sel;
                w.d   = d;
                exp_q.push_back(w);
                rx_exp[sel] = d;
            end
            tick();
        end
        vectors++;
        if (!acc) begin
            errors++;
            $display("FAIL push_timeout: write sel=%0d not accepted, required acceptance", sel);
        end
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        wr_valid = 1'b0;
        wr_sel   = 3'd0;
        wr_d     = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        vectors++;
        if (c_out !== 8'd0 || d_out !== 1'b0 || busy !== 1'b0 || sel_err !== 1'b0
            || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: c=%b d=%b busy=%b err=%b rdy=%b, required 0 0 0 0 1",
                     c_out, d_out, busy, sel_err, wr_ready);
        end
    endtask

    task automatic test_single();
        int   t0;
        logic [7:0] exp_c;
        logic exp_b;
        wr_t  w;
        wr_valid = 1'b1;
        wr_sel   = 3'd3;
        wr_d     = 1'b1;
        w.sel = 3; w.d = 1'b1;
        exp_q.push_back(w);
        tick();
        t0 = cyc;
        wr_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            exp_c = (k >= 2 + SETUP && k < 2 + SETUP + HIGH) ? 8'b0000_1000 : 8'd0;
            exp_b = (k <= 1 + SETUP + HIGH + HOLD);
            vectors++;
            if (c_out !== exp_c) begin
                errors++;
                $display("FAIL single_c_out: T+%0d got %b, required %b", cyc - t0, c_out, exp_c);
            end
            vectors++;
            if (busy !== exp_b) begin
                errors++;
                $display("FAIL single_busy: T+%0d got %b, required %b", cyc - t0, busy, exp_b);
            end
            if (k >= 2) begin
                vectors++;
                if (d_out !== 1'b1) begin
                    errors++;
                    $display("FAIL single_d_out: T+%0d got %b, required 1", cyc - t0, d_out);
                end
            end
        end
        vectors++;
        if (rx[3] !== 1'b1) begin
            errors++;
            $display("FAIL single_rx: register 3 reads %b, required 1", rx[3]);
        end
    endtask

    task automatic test_full();
        int s0;
        s0 = strobe_cnt;
        for (int i = 0; i < 6; i++) begin
            bw_sel[i] = i;
            bw_d[i]   = 1'(i);
        end
        drive_burst(6, 32'd0);
        drain();
        vectors++;
        if (strobe_cnt - s0 != 6) begin
            errors++;
            $display("FAIL full_count: %0d strobes, required 6", strobe_cnt - s0);
        end
    endtask

    task automatic test_same_reg();
        int s0;
        s0 = strobe_cnt;
        bw_sel[0] = 6; bw_d[0] = 1'b1;
        bw_sel[1] = 6; bw_d[1] = 1'b0;
        drive_burst(2, 32'd0);
        drain();
        vectors++;
        if (strobe_cnt - s0 != 2) begin
            errors++;
            $display("FAIL same_reg_count: %0d strobes, required 2", strobe_cnt - s0);
        end
        vectors++;
        if (last_gap != HOLD + SETUP) begin
            errors++;
            $display("FAIL same_reg_gap: low %0d cycles, required %0d", last_gap, HOLD + SETUP);
        end
        vectors++;
        if (rx[6] !== 1'b0) begin
            errors++;
            $display("FAIL same_reg_rx: register 6 reads %b, required 0", rx[6]);
        end
    endtask

    task automatic test_push_pop();
        int s0;
        s0 = strobe_cnt;
        for (int i = 0; i < 5; i++) begin
            bw_sel[i] = 7 - i;
            bw_d[i]   = 1'(i + 1);
        end
        // Skip cycle 4 so cycle 5 pushes while the head pops at three entries.
        drive_burst(5, 32'h0000_0010);
        drain();
        vectors++;
        if (strobe_cnt - s0 != 5) begin
            errors++;
            $display("FAIL push_pop_count: %0d strobes, required 5", strobe_cnt - s0);
        end
    endtask

    task automatic test_sel_err();
        err2_pulses   = 0;
        err2_high_cnt = 0;
        err2_last_c   = '0;
        main_err_cnt  = 0;
        bw_sel[0] = 7; bw_d[0] = 1'b1;
        bw_sel[1] = 2; bw_d[1] = 1'b1;
        drive_burst(2, 32'd0);
        drain();
        vectors++;
        if (err2_pulses != 1) begin
            errors++;
            $display("FAIL sel_err_pulses: %0d cycles high, required 1", err2_pulses);
        end
        vectors++;
        if (err2_pulse_cyc != first_push_cyc + 2 + SETUP) begin
            errors++;
            $display("FAIL sel_err_time: at T+%0d, required T+%0d",
                     err2_pulse_cyc - first_push_cyc, 2 + SETUP);
        end
        vectors++;
        if (err2_high_cnt != HIGH || err2_last_c !== 5'b00100) begin
            errors++;
            $display("FAIL sel_err_strobe: %0d high cycles last=%b, required %0d and 00100",
                     err2_high_cnt, err2_last_c, HIGH);
        end
        vectors++;
        if (main_err_cnt != 0) begin
            errors++;
            $display("FAIL sel_err_main: %0d pulses, required 0", main_err_cnt);
        end
        vectors++;
        if (busy2 !== 1'b0 || d_out2 !== 1'b1 || wr_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_idle: busy=%b d=%b rdy=%b, required 0 1 1",
                     busy2, d_out2, wr_ready2);
        end
    endtask

    task automatic test_reset_mid();
        int w, nz;
        bw_sel[0] = 1; bw_d[0] = 1'b1;
        bw_sel[1] = 2; bw_d[1] = 1'b0;
        bw_sel[2] = 4; bw_d[2] = 1'b1;
        drive_burst(3, 32'd0);
        w = 0;
        while (c_out == 8'd0 && w < 20) begin
            tick();
            w++;
        end
        tick();
        vectors++;
        if (c_out !== 8'b0000_0010) begin
            errors++;
            $display("FAIL reset_mid_pre: c_out=%b, required 00000010", c_out);
        end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        vectors++;
        if (c_out !== 8'd0 || d_out !== 1'b0 || busy !== 1'b0 || wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: c=%b d=%b busy=%b rdy=%b, required 0 0 0 1",
                     c_out, d_out, busy, wr_ready);
        end
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (c_out != 8'd0) nz++;
        end
        vectors++;
        if (nz != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after: %0d strobe cycles busy=%b, required 0 and 0",
                     nz, busy);
        end
    endtask

    task automatic test_random();
        bit written [8];
        int s0, sel;
        logic d;
        s0 = strobe_cnt;
        for (int i = 0; i < 8; i++) written[i] = 0;
        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(0, 7));
            d   = 1'($urandom_range(0, 1));
            written[sel] = 1;
            push_one(sel, d);
            if ($urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0;
                repeat ($urandom_range(0, 6)) tick();
            end
        end
        wr_valid = 1'b0;
        drain();
        vectors++;
        if (strobe_cnt - s0 != 30) begin
            errors++;
            $display("FAIL random_count: %0d strobes, required 30", strobe_cnt - s0);
        end
        for (int i = 0; i < 8; i++) begin
            if (written[i]) begin
                vectors++;
                if (rx[i] !== rx_exp[i]) begin
                    errors++;
                    $display("FAIL random_rx: register %0d reads %b, required %b",
                             i, rx[i], rx_exp[i]);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            rx[i]     = 1'b0;
            rx_exp[i] = 1'b0;
        end
        test_reset();
        test_single();
        test_full();
        test_same_reg();
        test_push_pop();
        test_sel_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
